// File: rtl/seq_mul.sv
// Parametrised add-and-shift multiplier: one multiplier bit per clock, LSB first, with signed/unsigned mode.
// Optional early termination when the remaining multiplier bits are all zero: define SEQ_MUL_EARLY_TERM_EN.
module seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sgn,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   c
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [2*WIDTH-1:0]   md;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mr;
    logic [CW-1:0]        count;
    logic                 s;
    logic                 last;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // The most negative value negates to itself, which reads correctly as the unsigned magnitude 2^(W-1).
    always_comb begin
        a_mag = (sgn && a[WIDTH-1]) ? -a : a;
        b_mag = (sgn && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
`ifdef SEQ_MUL_EARLY_TERM_EN
        last = (count == LAST) || (mr[WIDTH-1:1] == '0);
`else
        last = (count == LAST);
`endif
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = FIN;
            end
            FIN: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md    <= '0;
            mr    <= '0;
            acc   <= '0;
            count <= '0;
            s     <= 1'b0;
            done  <= 1'b0;
            c     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        s     <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        md    <= {{WIDTH{1'b0}}, a_mag};
                        mr    <= b_mag;
                        acc   <= '0;
                        count <= '0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (mr[0]) acc <= acc + md;
                    md    <= md << 1;
                    mr    <= mr >> 1;
                    count <= count + 1'b1;
                end
                FIN: begin
                    c    <= s ? -acc : acc;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul: vector table, hand-written corner sequences and random ops vs. an arithmetic model.
// Instantiates WIDTH=8 and WIDTH=16 copies; latency expectations follow SEQ_MUL_EARLY_TERM_EN.
module tb_seq_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a8, b8;
    logic        sgn8, start8, busy8, done8;
    logic [15:0] c8;
    logic [15:0] a16, b16;
    logic        sgn16, start16, busy16, done16;
    logic [31:0] c16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .sgn(sgn8), .start(start8),
        .busy(busy8), .done(done8), .c(c8)
    );

    seq_mul #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .sgn(sgn16), .start(start16),
        .busy(busy16), .done(done16), .c(c16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sgn;
        logic [15:0] c;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y, input int w, input bit s);
        longint vx = longint'(x);
        longint vy = longint'(y);
        longint p;
        if (s && x[w-1]) vx = vx - (longint'(1) << w);
        if (s && y[w-1]) vy = vy - (longint'(1) << w);
        p = vx * vy;
        return 64'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    function automatic int exp_lat(input logic [63:0] y, input int w, input bit s);
        longint m;
`ifdef SEQ_MUL_EARLY_TERM_EN
        int h;
`endif
        m = longint'(y);
        if (s && y[w-1]) m = (longint'(1) << w) - m;
`ifdef SEQ_MUL_EARLY_TERM_EN
        h = 0;
        for (int i = 0; i < w; i++) if (m[i]) h = i;
        return h + 2;
`else
        return w + 1;
`endif
    endfunction

    // One operation on the 8-bit instance; called #1 after a posedge with the DUT idle.
    task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input logic isgn,
                           input logic [15:0] expc, input string name);
        int lat = 0;
        int nb  = 0;
        a8 = ia; b8 = ib; sgn8 = isgn; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
        check({name, " done_drop"}, 64'(done8), 64'd0);
        while (done8 !== 1'b1 && lat < 100) begin
            if (busy8) nb++;
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat(64'(ib), 8, isgn)));
        check({name, " busy_cycles"}, 64'(nb), 64'(exp_lat(64'(ib), 8, isgn)));
        check({name, " c"}, 64'(c8), 64'(expc));
    endtask

    task automatic run_op16(input logic [15:0] ia, input logic [15:0] ib, input logic isgn,
                            input logic [31:0] expc, input string name);
        int lat = 0;
        a16 = ia; b16 = ib; sgn16 = isgn; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        while (done16 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat(64'(ib), 16, isgn)));
        check({name, " c"}, 64'(c16), 64'(expc));
    endtask

    initial begin
        vec_t vecs[10];
        int   lat;
        int   nb;
        logic [7:0] ra, rb;
        logic       rs;

        vecs[0] = '{8'd100,  8'd65,  1'b0, 16'h1964};
        vecs[1] = '{8'hFF,   8'hFF,  1'b0, 16'hFE01};
        vecs[2] = '{8'hFD,   8'h05,  1'b1, 16'hFFF1};
        vecs[3] = '{8'h80,   8'h80,  1'b1, 16'h4000};
        vecs[4] = '{8'h80,   8'h01,  1'b1, 16'hFF80};
        vecs[5] = '{8'h00,   8'h00,  1'b0, 16'h0000};
        vecs[6] = '{8'hFF,   8'hFF,  1'b1, 16'h0001};
        vecs[7] = '{8'hFF,   8'h01,  1'b0, 16'h00FF};
        vecs[8] = '{8'h7F,   8'h80,  1'b1, 16'hC080};
        vecs[9] = '{8'h7F,   8'h7F,  1'b1, 16'h3F01};

        rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
        a8 = '0; b8 = '0; sgn8 = 1'b0; a16 = '0; b16 = '0; sgn16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy8), 64'd0);
        check("reset done", 64'(done8), 64'd0);
        check("reset c", 64'(c8), 64'd0);
        check("reset c16", 64'(c16), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_op8(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].c, $sformatf("vec%0d", i));

        // Second request while running must be ignored.
        a8 = 8'd12; b8 = 8'd10; sgn8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        a8 = 8'd7; b8 = 8'd7; sgn8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 3;
        while (done8 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("midrun latency", 64'(lat), 64'(exp_lat(64'd10, 8, 1'b0)));
        check("midrun c", 64'(c8), 64'd120);
        nb = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (busy8 || !done8) nb++;
        end
        check("midrun no_second_op", 64'(nb), 64'd0);
        check("midrun c_hold", 64'(c8), 64'd120);

        // Reset during the fourth RUN cycle.
        a8 = 8'd200; b8 = 8'd255; sgn8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset busy", 64'(busy8), 64'd0);
        check("midreset done", 64'(done8), 64'd0);
        check("midreset c", 64'(c8), 64'd0);
        run_op8(8'd3, 8'd4, 1'b0, 16'd12, "after_reset");

        // Start held high: done lasts one cycle before the next op is accepted.
        a8 = 8'd9; b8 = 8'd11; sgn8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (done8 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("held latency", 64'(lat), 64'(exp_lat(64'd11, 8, 1'b0)));
        check("held c", 64'(c8), 64'd99);
        @(posedge clk); #1;
        check("held done_one_cycle", 64'(done8), 64'd0);
        check("held busy_again", 64'(busy8), 64'd1);
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("held second c", 64'(c8), 64'd99);

        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            run_op8(ra, rb, rs, 16'(model(64'(ra), 64'(rb), 8, rs)), $sformatf("rnd%0d", i));
        end

        run_op16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "w16 min_x_max");
        run_op16(16'h1234, 16'h0000, 1'b1, 32'h0, "w16 b_zero");
        run_op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16 max_unsigned");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
